// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and a two's-complement helper.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_ITERS = 32;

    // Absolute value of a 32-bit two's-complement word (0x80000000 maps to itself).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// One shared 33-bit adder does shift-add multiply and restoring-divide trial subtracts.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(MDU_ITERS);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e         op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [XLEN-1:0] mq_q, mq_d;        // multiplier / dividend-then-quotient
    logic [XLEN-1:0] mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [XLEN-1:0] rs_raw_q, rs_raw_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dbz_q, dbz_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_flag_q, dbz_flag_d;

    logic            in_signed;
    logic            rs_neg, rt_neg;
    logic [XLEN-1:0] rs_mag, rt_mag;
    logic            is_mul;
    logic [XLEN:0]   add_a, add_b, sum, partial;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0] quo_neg, rem_neg;

    assign in_signed = ~op[0];
    assign rs_neg    = in_signed & rs_val[XLEN-1];
    assign rt_neg    = in_signed & rt_val[XLEN-1];
    assign rs_mag    = rs_neg ? abs32(rs_val) : rs_val;
    assign rt_mag    = rt_neg ? abs32(rt_val) : rt_val;

    // Multiply adds the multiplicand; divide subtracts the divisor from {acc, next dividend bit}.
    assign is_mul  = ~op_q[1];
    assign add_a   = is_mul ? {1'b0, acc_q} : {acc_q, mq_q[XLEN-1]};
    assign add_b   = is_mul ? {1'b0, mcand_q} : ~{1'b0, mcand_q};
    assign sum     = add_a + add_b + {{XLEN{1'b0}}, ~is_mul};
    assign partial = mq_q[0] ? sum : {1'b0, acc_q};

    assign prod_neg = -{acc_q, mq_q};
    assign quo_neg  = -mq_q;
    assign rem_neg  = -acc_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        mcand_d    = mcand_q;
        rs_raw_d   = rs_raw_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_flag_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    op_d      = mdu_op_e'(op);
                    acc_d     = '0;
                    mq_d      = op[1] ? rs_mag : rt_mag;
                    mcand_d   = op[1] ? rt_mag : rs_mag;
                    rs_raw_d  = rs_val;
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    dbz_d     = op[1] & (rt_val == '0);
                end
            end
            CALC: begin
                if (is_mul) begin
                    acc_d = partial[XLEN:1];
                    mq_d  = {partial[0], mq_q[XLEN-1:1]};
                end else if (!sum[XLEN]) begin
                    acc_d = sum[XLEN-1:0];
                    mq_d  = {mq_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[XLEN-2:0], mq_q[XLEN-1]};
                    mq_d  = {mq_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(MDU_ITERS - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dbz_q) begin
                    lo_d       = '1;
                    hi_d       = rs_raw_q;
                    dbz_flag_d = 1'b1;
                end else if (is_mul) begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : {acc_q, mq_q};
                end else begin
                    lo_d = neg_res_q ? quo_neg : mq_q;
                    hi_d = neg_rem_q ? rem_neg : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: register process uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= MDU_MULT;
            acc_q      <= '0;
            mq_q       <= '0;
            mcand_q    <= '0;
            rs_raw_q   <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            mcand_q    <= mcand_d;
            rs_raw_q   <= rs_raw_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_flag_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a behavioural model pushes expected HI/LO at launch,
// and each done pulse pops and compares.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mult_div_unit #(.XLEN(32)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        p     = '0;
        case (o)
            2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Drive a launch at the current negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (track) sb_q.push_back(model(o, a, b));
        @(negedge Clk);
        start  = 1'b0;
        op     = 2'($urandom_range(3));
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    // Waits (bounded) for done; n0 = negedges already elapsed since the negedge after acceptance.
    task automatic wait_done(input string tag, input int n0);
        int   n;
        bit   busy_ok;
        exp_t e;
        n       = n0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge Clk);
            n++;
        end
        check({tag, " busy_while_running"}, 64'(busy_ok), 64'(1));
        check({tag, " latency"}, 64'(n), 64'(33));
        check({tag, " busy_at_done"}, 64'(busy), 64'(0));
        check({tag, " scoreboard_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e.hi));
            check({tag, " lo"}, 64'(lo), 64'(e.lo));
            check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
        end
    endtask

    initial begin
        logic [31:0] edge_vals [5];
        bit          quiet;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (3) @(negedge Clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset dbz", 64'(div_by_zero), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        reset = 1'b0;
        @(negedge Clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max", 0);
        check("multu_max hi const", 64'(hi), 64'(32'hFFFF_FFFE));
        check("multu_max lo const", 64'(lo), 64'(32'h0000_0001));
        @(negedge Clk);
        check("multu_max done_one_cycle", 64'(done), 64'(0));

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("mult_neg", 0);
        check("mult_neg lo const", 64'(lo), 64'(32'hFFFF_FFF1));
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);   // accepted in the done cycle
        wait_done("div_b2b", 0);
        check("div_b2b lo const", 64'(lo), 64'(32'hFFFF_FFFD));
        check("div_b2b hi const", 64'(hi), 64'(32'hFFFF_FFFF));

        issue(2'b11, 32'd7, 32'd0, 1'b1);
        wait_done("divu_zero", 0);
        issue(2'b10, 32'd0, 32'd0, 1'b1);
        wait_done("div_zero", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_ovf", 0);
        check("div_ovf lo const", 64'(lo), 64'(32'h8000_0000));

        // Start and MTHI asserted mid-operation must both be dropped.
        issue(2'b01, 32'd2, 32'd3, 1'b1);
        repeat (4) @(negedge Clk);
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd9;
        rt_val = 32'd3;
        hi_we  = 1'b1;
        wdata  = 32'h0000_DEAD;
        @(negedge Clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("busy_ignore hi_unchanged", 64'(hi), 64'(32'h8000_0000 & 32'h0));
        wait_done("busy_ignore", 5);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        check("busy_ignore no_queued_op", 64'(quiet), 64'(1));

        edge_vals[0] = 32'd0;
        edge_vals[1] = 32'd1;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            edge_vals[4] = $urandom;
            a = edge_vals[$urandom_range(4)];
            edge_vals[4] = $urandom;
            b = (i % 3 == 0) ? edge_vals[$urandom_range(4)] : $urandom;
            issue(2'($urandom_range(3)), a, b, 1'b1);
            wait_done($sformatf("rand%0d", i), 0);
        end

        // MTHI together with start: visible next cycle, then overwritten by the result.
        @(negedge Clk);
        hi_we = 1'b1;
        wdata = 32'h0000_0055;
        issue(2'b01, 32'd4, 32'd4, 1'b1);
        hi_we = 1'b0;
        check("we_with_start hi", 64'(hi), 64'(32'h0000_0055));
        wait_done("we_with_start", 0);

        @(negedge Clk);
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge Clk);
        lo_we = 1'b0;
        check("mtlo lo", 64'(lo), 64'(32'h1234_5678));
        hi_we = 1'b1;
        wdata = 32'hCAFE_BABE;
        @(negedge Clk);
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'(32'hCAFE_BABE));
        check("mthi lo_kept", 64'(lo), 64'(32'h1234_5678));
        check("mthi busy", 64'(busy), 64'(0));

        issue(2'b00, 32'hFFFF_FFFB, 32'd7, 1'b0);
        repeat (9) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        check("midreset done", 64'(done), 64'(0));
        reset = 1'b0;
        quiet = 1'b1;
        repeat (45) begin
            @(negedge Clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("midreset no_done", 64'(quiet), 64'(1));
        check("scoreboard drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
